seqgen_101_tx: RTL and testbench

- Transmit-side counterpart of the 101 sequence detector. Accepts a parallel word over a valid/ready handshake and serializes it onto a single-bit line `x`.
- Frame format, in order: preamble 1-0-1, then DATA_W data bits MSB first, then one even-parity bit, then an idle gap of 0s.
- Drives the `x` input of the detector side in loopback benches and in the serial link top level.

---
 rtl/seqgen_pkg.sv | 37 +++
 rtl/seq_bit_timer.sv | 40 ++++
 rtl/seqgen_101_tx.sv | 144 ++++++++++++++
 tb/tb_seqgen_101_tx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seqgen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seqgen_pkg
//  Purpose  : Shared types and constants for the 101-preamble serial
//             transmitter: FSM state encoding, preamble pattern and the
//             even-parity helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package seqgen_pkg;

   // Encoding 3'd7 is unused; the FSM recovers from it to IDLE.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRE_A = 3'd1,
      PRE_B = 3'd2,
      PRE_C = 3'd3,
      DATA  = 3'd4,
      PAR   = 3'd5,
      GAP   = 3'd6
   } state_t;

   // Preamble is sent MSB first: PRE_A carries bit 2, PRE_C carries bit 0.
   localparam logic [2:0] PREAMBLE = 3'b101;
   localparam int         PRE_LEN  = 3;

   // Widest payload the parity helper folds; narrower words are zero-extended,
   // which does not change even parity.
   localparam int PARITY_MAX_W = 64;

   // Even parity: the bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
      return ^word;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module   : seq_bit_timer
//  Purpose  : Bit-period divider. Counts 0..BIT_DIV-1 while enabled and
//             raises tick in the last cycle of each bit period.
//  Ports    : clk  - system clock, rising edge
//             rst  - asynchronous active-high reset
//             en   - count enable; the counter is held at 0 while low
//             tick - high in the final cycle of a bit period
//  Revision : 1.0 - initial release
// ============================================================================
module seq_bit_timer #(
   parameter int BIT_DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   // At least one bit wide so BIT_DIV=1 needs no special case: the counter
   // then sits at 0 and every enabled cycle is a tick.
   localparam int CNT_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

   logic [CNT_W-1:0] cnt;

   assign tick = en && (cnt == CNT_W'(BIT_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!en || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/seqgen_101_tx.sv
`default_nettype none
// ============================================================================
//  Module   : seqgen_101_tx
//  Purpose  : Serializer that frames a parallel word as
//             1-0-1 preamble, DATA_W data bits MSB first, one even-parity
//             bit, then GAP_BITS bit periods of 0, each bit BIT_DIV cycles.
//  Ports    : clk      - system clock, rising edge
//             rst      - asynchronous active-high reset
//             in_data  - word to transmit (DATA_W bits, DATA_W <= 64)
//             in_valid - in_data is valid
//             in_ready - block accepts a word (high only in IDLE)
//             x        - registered serial output
//             busy     - frame in progress (inverse of in_ready)
//             done     - one-cycle pulse in the first IDLE cycle after GAP
//  Revision : 1.0 - initial release
// ============================================================================
module seqgen_101_tx
   import seqgen_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int BIT_DIV  = 1,
   parameter int GAP_BITS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              x,
   output logic              busy,
   output logic              done
);

   // One counter serves both the data field and the gap, so it is sized
   // for whichever of the two is longer.
   localparam int CNT_MAX = (DATA_W > GAP_BITS) ? DATA_W : GAP_BITS;
   localparam int BCNT_W  = $clog2(CNT_MAX + 1);

   state_t            state, state_next;
   logic [DATA_W-1:0] shift_q, shift_next;
   logic [BCNT_W-1:0] bcnt, bcnt_next;
   logic              par_q, par_next;
   logic              x_next;
   logic              done_next;
   logic              tick;
   logic              timer_en;

   assign in_ready = (state == IDLE);
   assign busy     = ~in_ready;
   assign timer_en = (state != IDLE);

   seq_bit_timer #(
      .BIT_DIV (BIT_DIV)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .en   (timer_en),
      .tick (tick)
   );

   always_comb begin
      state_next = state;
      shift_next = shift_q;
      bcnt_next  = bcnt;
      par_next   = par_q;
      done_next  = 1'b0;

      case (state)
         IDLE: begin
            if (in_valid) begin
               state_next = PRE_A;
               shift_next = in_data;
               par_next   = even_parity(PARITY_MAX_W'(in_data));
               bcnt_next  = '0;
            end
         end
         PRE_A: if (tick) state_next = PRE_B;
         PRE_B: if (tick) state_next = PRE_C;
         PRE_C: if (tick) state_next = DATA;
         DATA: begin
            if (tick) begin
               shift_next = shift_q << 1;
               if (bcnt == BCNT_W'(DATA_W - 1)) begin
                  state_next = PAR;
                  bcnt_next  = '0;
               end else begin
                  bcnt_next = bcnt + 1'b1;
               end
            end
         end
         PAR: if (tick) state_next = GAP;
         GAP: begin
            if (tick) begin
               if (bcnt == BCNT_W'(GAP_BITS - 1)) begin
                  state_next = IDLE;
                  bcnt_next  = '0;
                  done_next  = 1'b1;
               end else begin
                  bcnt_next = bcnt + 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            shift_next = '0;
            bcnt_next  = '0;
            par_next   = 1'b0;
         end
      endcase

      // x is registered from the next state so that it lines up with the
      // state register: the first preamble bit shows in the cycle right
      // after the accept edge.
      x_next = 1'b0;
      case (state_next)
         PRE_A:   x_next = PREAMBLE[PRE_LEN-1];
         PRE_B:   x_next = PREAMBLE[PRE_LEN-2];
         PRE_C:   x_next = PREAMBLE[PRE_LEN-3];
         DATA:    x_next = shift_next[DATA_W-1];
         PAR:     x_next = par_next;
         default: x_next = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         shift_q <= '0;
         bcnt    <= '0;
         par_q   <= 1'b0;
         x       <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_next;
         shift_q <= shift_next;
         bcnt    <= bcnt_next;
         par_q   <= par_next;
         x       <= x_next;
         done    <= done_next;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seqgen_101_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seqgen_101_tx
//  Purpose  : Self-checking bench for seqgen_101_tx. Two instances: one with
//             BIT_DIV=1 and one with BIT_DIV=4. Expected per-cycle outputs
//             are queued when a word is offered and popped one per cycle.
//  Ports    : none (testbench)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seqgen_101_tx;

   typedef struct packed {
      logic x;
      logic ready;
      logic done;
   } exp_t;

   typedef struct packed {
      logic [7:0]  data;
      logic [12:0] bits;   // preamble, data MSB first, parity, gap
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] in_data1 = 8'h00;
   logic [7:0] in_data4 = 8'h00;
   logic       in_valid1 = 1'b0;
   logic       in_valid4 = 1'b0;
   logic       in_ready1, x1, busy1, done1;
   logic       in_ready4, x4, busy4, done4;

   exp_t q1[$];
   exp_t q4[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   seqgen_101_tx #(
      .DATA_W   (8),
      .BIT_DIV  (1),
      .GAP_BITS (1)
   ) dut1 (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data1),
      .in_valid (in_valid1),
      .in_ready (in_ready1),
      .x        (x1),
      .busy     (busy1),
      .done     (done1)
   );

   seqgen_101_tx #(
      .DATA_W   (8),
      .BIT_DIV  (4),
      .GAP_BITS (1)
   ) dut4 (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data4),
      .in_valid (in_valid4),
      .in_ready (in_ready4),
      .x        (x4),
      .busy     (busy4),
      .done     (done4)
   );

   task automatic check_bit(input string name, input logic act, input logic req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %b, required %b at t=%0t", name, act, req, $time);
      end
   endtask

   task automatic check_dut(input int which, input exp_t e);
      if (which == 1) begin
         check_bit("dut1.x",        x1,        e.x);
         check_bit("dut1.in_ready", in_ready1, e.ready);
         check_bit("dut1.busy",     busy1,     !e.ready);
         check_bit("dut1.done",     done1,     e.done);
      end else begin
         check_bit("dut4.x",        x4,        e.x);
         check_bit("dut4.in_ready", in_ready4, e.ready);
         check_bit("dut4.busy",     busy4,     !e.ready);
         check_bit("dut4.done",     done4,     e.done);
      end
   endtask

   // Advance one clock, then compare each DUT that has a pending expectation.
   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      if (q1.size() > 0) begin
         e = q1.pop_front();
         check_dut(1, e);
      end
      if (q4.size() > 0) begin
         e = q4.pop_front();
         check_dut(4, e);
      end
   endtask

   task automatic push_exp(input int which, input logic xv, input logic rv, input logic dv);
      exp_t e;
      e.x     = xv;
      e.ready = rv;
      e.done  = dv;
      if (which == 1) q1.push_back(e);
      else            q4.push_back(e);
   endtask

   // Whole frame held div cycles per bit, then the first IDLE cycle with done.
   task automatic push_frame(input int which, input logic [12:0] bits, input int div);
      for (int i = 12; i >= 0; i--) begin
         for (int k = 0; k < div; k++) push_exp(which, bits[i], 1'b0, 1'b0);
      end
      push_exp(which, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic push_idle(input int which, input int n);
      for (int i = 0; i < n; i++) push_exp(which, 1'b0, 1'b1, 1'b0);
   endtask

   // Runs until both queues are empty. Called while in cycle 1 of a frame.
   // ev_kind 1: pulse in_valid1 with 8'hFF in cycle ev_cycle.
   // ev_kind 2: drop in_valid1 in cycle ev_cycle.
   task automatic drain(input int ev_cycle, input int ev_kind);
      int c = 1;
      while (q1.size() > 0 || q4.size() > 0) begin
         if (c == ev_cycle) begin
            if (ev_kind == 1) begin
               in_valid1 = 1'b1;
               in_data1  = 8'hFF;
            end else begin
               in_valid1 = 1'b0;
            end
         end
         if (ev_kind == 1 && c == ev_cycle + 1) in_valid1 = 1'b0;
         step();
         c++;
      end
   endtask

   initial begin
      vec_t       tbl[7];
      exp_t       e;
      logic [12:0] ff_bits;

      tbl[0] = '{8'hA5, 13'b101_10100101_0_0};
      tbl[1] = '{8'h01, 13'b101_00000001_1_0};
      tbl[2] = '{8'hFF, 13'b101_11111111_0_0};
      tbl[3] = '{8'h00, 13'b101_00000000_0_0};
      tbl[4] = '{8'h5A, 13'b101_01011010_0_0};
      tbl[5] = '{8'h3C, 13'b101_00111100_0_0};
      tbl[6] = '{8'h07, 13'b101_00000111_1_0};

      // Reset takes effect before any clock edge.
      #1 rst = 1'b1;
      #1;
      e = '{x: 1'b0, ready: 1'b1, done: 1'b0};
      check_dut(1, e);
      check_dut(4, e);
      @(posedge clk);
      #1 rst = 1'b0;
      push_idle(1, 2);
      push_idle(4, 2);
      step();
      step();

      // Table of single frames, each followed by a check that done lasts one cycle.
      for (int i = 0; i < 7; i++) begin
         in_data1  = tbl[i].data;
         in_valid1 = 1'b1;
         push_frame(1, tbl[i].bits, 1);
         push_idle(1, 1);
         step();
         in_valid1 = 1'b0;
         drain(0, 0);
      end

      // Bit divider of 4: 52-cycle frame, data MSB spans cycles 13-16.
      in_data4  = 8'h80;
      in_valid4 = 1'b1;
      push_frame(4, 13'b101_10000000_1_0, 4);
      push_idle(4, 2);
      step();
      in_valid4 = 1'b0;
      drain(0, 0);

      // Back-to-back: second word accepted in the done cycle of the first.
      in_data1  = 8'hA5;
      in_valid1 = 1'b1;
      push_frame(1, tbl[0].bits, 1);
      push_frame(1, tbl[4].bits, 1);
      push_idle(1, 2);
      step();
      in_data1 = 8'h5A;
      drain(15, 2);

      // in_valid pulsed during DATA is ignored; no second frame follows.
      in_data1  = 8'hA5;
      in_valid1 = 1'b1;
      push_frame(1, tbl[0].bits, 1);
      push_idle(1, 3);
      step();
      in_valid1 = 1'b0;
      drain(6, 1);

      // Reset during data bit 5 of an all-ones word: x is 1 just before.
      ff_bits   = tbl[2].bits;
      in_data1  = 8'hFF;
      in_valid1 = 1'b1;
      for (int i = 12; i >= 5; i--) push_exp(1, ff_bits[i], 1'b0, 1'b0);
      step();
      in_valid1 = 1'b0;
      drain(0, 0);
      #3 rst = 1'b1;
      #1;
      e = '{x: 1'b0, ready: 1'b1, done: 1'b0};
      check_dut(1, e);
      push_idle(1, 2);
      step();
      step();
      rst = 1'b0;
      push_idle(1, 3);
      step();
      step();
      step();

      // Recovery frame after the aborted one.
      in_data1  = 8'h3C;
      in_valid1 = 1'b1;
      push_frame(1, tbl[5].bits, 1);
      push_idle(1, 1);
      step();
      in_valid1 = 1'b0;
      drain(0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
